// File: rtl/rot_pkg.sv
// Shared definitions for the rotator family: search states, width helper and
// the rotate-direction encoding used by both the rotator and its inverse.
package rot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } rot_state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  function automatic int rot_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/rot1.sv
// Single-position rotate of a W-bit word; dir selects right or left.
module rot1
  import rot_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] d,
  input  logic         dir,
  output logic [W-1:0] q
);

  always_comb begin
    if (dir == DIR_LEFT) q = {d[W-2:0], d[W-1]};
    else                 q = {d[0], d[W-1:1]};
  end

endmodule

// File: rtl/rotate_amount_finder.sv
// Finds the rotation amount and direction that maps a onto y, one candidate per cycle.
// Optional sticky overrun flag for start-while-busy: ROT_FIND_OVERRUN_EN.
//
// state  | meaning
// IDLE   | waiting for start; last result held on found/amt/lr
// SEARCH | compare both rotated copies against target, then step k
// DONE   | result valid, done pulses for one cycle
module rotate_amount_finder
  import rot_pkg::*;
#(
  parameter  int N = 3,
  localparam int W = rot_width(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [N-1:0] amt,
  output logic         lr
`ifdef ROT_FIND_OVERRUN_EN
  ,
  output logic         overrun
`endif
);

  localparam logic [N-1:0] K_HALF = (N)'(W / 2);
  localparam logic [N-1:0] K_ONE  = (N)'(1);

  rot_state_t   state, state_nxt;
  logic [N-1:0] k, k_nxt;
  logic [W-1:0] rr, rr_nxt, rr_rot;
  logic [W-1:0] rl, rl_nxt, rl_rot;
  logic [W-1:0] yt, yt_nxt;
  logic         found_nxt, lr_nxt;
  logic [N-1:0] amt_nxt;

  rot1 #(.W(W)) u_rot_r (.d(rr), .dir(DIR_RIGHT), .q(rr_rot));
  rot1 #(.W(W)) u_rot_l (.d(rl), .dir(DIR_LEFT),  .q(rl_rot));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      k     <= '0;
      rr    <= '0;
      rl    <= '0;
      yt    <= '0;
      found <= 1'b0;
      amt   <= '0;
      lr    <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      rr    <= rr_nxt;
      rl    <= rl_nxt;
      yt    <= yt_nxt;
      found <= found_nxt;
      amt   <= amt_nxt;
      lr    <= lr_nxt;
    end
  end

  // Right is tested first so a both-direction match (k = 0 or W/2) reports right.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    rr_nxt    = rr;
    rl_nxt    = rl;
    yt_nxt    = yt;
    found_nxt = found;
    amt_nxt   = amt;
    lr_nxt    = lr;
    case (state)
      IDLE: begin
        if (start) begin
          rr_nxt    = a;
          rl_nxt    = a;
          yt_nxt    = y;
          k_nxt     = '0;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (rr == yt) begin
          found_nxt = 1'b1;
          amt_nxt   = k;
          lr_nxt    = DIR_RIGHT;
          state_nxt = DONE;
        end else if (rl == yt) begin
          found_nxt = 1'b1;
          amt_nxt   = k;
          lr_nxt    = DIR_LEFT;
          state_nxt = DONE;
        end else if (k == K_HALF) begin
          found_nxt = 1'b0;
          amt_nxt   = '0;
          lr_nxt    = DIR_RIGHT;
          state_nxt = DONE;
        end else begin
          rr_nxt = rr_rot;
          rl_nxt = rl_rot;
          k_nxt  = k + K_ONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

`ifdef ROT_FIND_OVERRUN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     overrun <= 1'b0;
    else if (state == IDLE && start) overrun <= 1'b0;
    else if (start && busy)          overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_rotate_amount_finder.sv
// Randomized and directed check of rotate_amount_finder (N = 3) against a
// brute-force rotation model; also covers ROT_FIND_OVERRUN_EN when defined.
module tb_rotate_amount_finder;

  localparam int N = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a, y;
  logic         busy, done, found, lr;
  logic [N-1:0] amt;
`ifdef ROT_FIND_OVERRUN_EN
  logic         overrun;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  rotate_amount_finder #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .amt     (amt),
    .lr      (lr)
`ifdef ROT_FIND_OVERRUN_EN
    ,
    .overrun (overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Smallest amount 0..W/2 wins; at equal amount right is preferred.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] my,
                                output logic f, output logic [N-1:0] am, output logic d);
    logic [2*W-1:0] dd, t;
    f = 1'b0; am = '0; d = 1'b0;
    dd = {ma, ma};
    for (int s = 0; s <= W / 2; s++) begin
      if (!f) begin
        t = dd >> s;
        if (t[W-1:0] == my) begin
          f = 1'b1; am = s[N-1:0]; d = 1'b0;
        end else begin
          t = dd << s;
          if (t[2*W-1:W] == my) begin
            f = 1'b1; am = s[N-1:0]; d = 1'b1;
          end
        end
      end
    end
  endfunction

  // Latency is counted in edges after the accepting edge until done is visible.
  task automatic do_req(input string tag, input logic [W-1:0] ta, input logic [W-1:0] ty,
                        input bit noisy);
    logic         ef, el;
    logic [N-1:0] ea;
    int           lat, elat;
    bit           got, busy_ok, extra;
    model(ta, ty, ef, ea, el);
    elat = ef ? int'(ea) + 1 : W / 2 + 1;
    @(negedge clk);
    a = ta; y = ty; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); y = W'($urandom);
    lat = 0; got = 0; busy_ok = 1; extra = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1;
      else begin
        if (!busy) busy_ok = 0;
        if (noisy && $urandom_range(0, 3) == 0) begin
          start = 1'b1; extra = 1;
          a = W'($urandom); y = W'($urandom);
        end else start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_busy_during"}, 32'(busy_ok & busy), 32'd1);
    chk({tag, "_found"}, 32'(found), 32'(ef));
    chk({tag, "_amt"}, 32'(amt), 32'(ea));
    chk({tag, "_lr"}, 32'(lr), 32'(el));
`ifdef ROT_FIND_OVERRUN_EN
    chk({tag, "_overrun"}, 32'(overrun), 32'(extra));
`endif
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
    chk({tag, "_hold"}, 32'({found, amt, lr}), 32'({ef, ea, el}));
  endtask

  initial begin
    logic [W-1:0] ra, ry, dd;
    logic [2*W-1:0] d2;
    bit saw_done;
    reset_n = 1'b0; start = 1'b0; a = '0; y = '0;
    #1;
    chk("reset_outputs", 32'({busy, done, found, amt, lr}), 32'd0);
`ifdef ROT_FIND_OVERRUN_EN
    chk("reset_overrun", 32'(overrun), 32'd0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    do_req("left3",     8'b01010110, 8'b10110010, 0);
    do_req("right1",    8'b11110000, 8'b01111000, 0);
    do_req("tie4",      8'b01110101, 8'b01010111, 0);
    do_req("notfound",  8'b10000000, 8'b00000011, 0);
    do_req("equal",     8'b11111000, 8'b11111000, 0);
    do_req("zeros",     8'h00,       8'h00,       0);
    do_req("ones",      8'hff,       8'hff,       0);

    // Second start while busy, then reset mid-search: no done afterwards.
    @(negedge clk);
    a = 8'b01010110; y = 8'b10110010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 8'h0f; y = 8'h0f;
    @(posedge clk); #1;
    start = 1'b0;
    chk("second_start_busy", 32'(busy), 32'd1);
`ifdef ROT_FIND_OVERRUN_EN
    chk("second_start_overrun", 32'(overrun), 32'd1);
`endif
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({busy, done, found, amt, lr}), 32'd0);
`ifdef ROT_FIND_OVERRUN_EN
    chk("midreset_overrun", 32'(overrun), 32'd0);
`endif
    saw_done = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    chk("midreset_no_done", 32'(saw_done), 32'd0);
    do_req("after_reset", 8'b01010110, 8'b10110010, 0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: ra = '1;
        default: ;
      endcase
      d2 = {ra, ra};
      d2 = d2 >> $urandom_range(0, W - 1);
      dd = d2[W-1:0];
      ry = ($urandom_range(0, 2) == 0) ? W'($urandom) : dd;
      do_req($sformatf("rand%0d", i), ra, ry, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rotate_amount_finder.md
Name: rotate_amount_finder

Overview:
- Inverse of the combinational barrel rotator.
- Given a source word `a` and a rotated word `y`, iteratively searches for the rotation amount and direction that maps `a` onto `y`.
- Sits beside the rotator in self-check and alignment paths. Uses a start/busy/done handshake and a multi-cycle search, one candidate amount per cycle.

Parameters:
- N, 3, log2 of data width; data width W = 2**N; legal N >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- a  in  W  source word; captured when start is accepted.
- y  in  W  target (rotated) word; captured when start is accepted.
- busy  out  1  high in SEARCH and DONE.
- done  out  1  one-cycle pulse when a result is valid.
- found  out  1  1 = rotation found, 0 = `y` is not any rotation of `a`.
- amt  out  N  rotation amount, 0..W/2.
- lr  out  1  0 = right rotation, 1 = left rotation.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, found, amt, lr all 0; internal k = 0.
- Reset mid-search aborts the search immediately. No done pulse is produced for the aborted request.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - On start = 1: capture `a` into rr and rl, capture `y` into yt, set k = 0, go to SEARCH.
  - found, amt and lr keep their previous values until the next result.
- SEARCH, each cycle (k counts 0..W/2):
  - If rr == yt: found = 1, amt = k, lr = 0, go to DONE.
  - Else if rl == yt: found = 1, amt = k, lr = 1, go to DONE.
  - Else if k == W/2: found = 0, amt = 0, lr = 0, go to DONE.
  - Else: rr = rotr(rr, 1), rl = rotl(rl, 1), k = k + 1.
- Tie rule: when both directions match at the same k (k = 0 or k = W/2), right wins (lr = 0).
- DONE: done = 1 for exactly this cycle, busy = 1, then go to IDLE.
- Latency: start sampled at edge 0; result registered and done high in the cycle after edge k+1.
  - Match at k: done is seen at edge k+2.
  - Not found: done at edge W/2+2.
- start while busy is ignored; no queuing.
- The captured `a` and `y` are used for the whole search. Input changes after capture have no effect.
- k width N; W/2 = 2**(N-1) fits in N bits without wrap.
- All-zero or all-one `a` equal to `y`: match at k = 0, amt = 0, lr = 0.

Optional Feature:
- Macro ROT_FIND_OVERRUN_EN.
- When defined: extra output `overrun` (1 bit).
  - Sticky; set when start = 1 while busy = 1.
  - Cleared only by reset or by a start accepted in IDLE.
  - Reset value 0.
- When undefined: port absent; start while busy silently ignored as above.

Decomposition:
- Shared package rot_pkg:
  - state enum rot_state_t {IDLE, SEARCH, DONE}.
  - Constant function for W from N.
  - Direction constants DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1; the combinational rotator uses the same encoding.
- One natural sub-module: rot1, a parameterised single-position rotate (width W, direction input). It is instantiated twice, for rr and rl.
- Control FSM and counter stay in the top module.

Test Plan (N = 3, W = 8):
- a = 01010110, y = 10110010, start -> found = 1, amt = 3, lr = 1; done pulse at edge 5; busy high from edge 1 through edge 5.
- a = 11110000, y = 01111000 -> found = 1, amt = 1, lr = 0; done at edge 3.
- a = 01110101, y = 01010111 (rotation by 4 both ways) -> tie rule: found = 1, amt = 4, lr = 0; done at edge 6.
- a = 10000000, y = 00000011 -> found = 0, amt = 0, lr = 0; done at edge 6.
- a = y = 11111000 -> found = 1, amt = 0, lr = 0; done at edge 2.
- Start a = 01010110, y = 10110010, then second start at edge 2, then reset_n low at edge 3:
  - Second start is ignored (overrun = 1 if ROT_FIND_OVERRUN_EN).
  - After reset all outputs are 0 and no done pulse occurs.
  - Next start completes normally.
